data_mem_access: RTL

Memory-access (MEM) stage data-path controller of the MIPS pipeline. Takes load/store requests from the EX/MEM pipeline register and performs byte-lane alignment and byte-enable generation. Runs a req/ack handshake with the data memory and stalls the pipeline until the access completes. Delivers right-justified, zero-filled load data with its size mask and unsigned flag to the downstream load sign-extension stage.

---
 rtl/data_mem_access.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_access.sv
// MEM-stage data-path controller: aligns load/store requests to byte lanes,
// runs a req/ack handshake with data memory and stalls the pipeline until
// the access completes. Load data leaves right-justified and zero-filled.
module data_mem_access #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 32,
    parameter int NB_MASK = 2
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_valid,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic [NB_MASK-1:0] i_mascara,
    input  logic               i_is_unsigned,
    output logic               o_stall,
    output logic               o_dmem_req,
    output logic               o_dmem_we,
    output logic [NB_ADDR-1:0] o_dmem_addr,
    output logic [NB_DATA-1:0] o_dmem_wdata,
    output logic [3:0]         o_dmem_be,
    input  logic               i_dmem_ack,
    input  logic [NB_DATA-1:0] i_dmem_rdata,
    output logic [NB_DATA-1:0] o_dato,
    output logic [NB_MASK-1:0] o_mascara,
    output logic               o_is_unsigned,
    output logic               o_load_valid,
    output logic               o_fault
);

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_req;
    logic               w_fault;
    logic               w_accept;
    logic               w_done;
    logic [NB_DATA-1:0] w_wdata_al;
    logic [3:0]         w_be;
    logic [NB_DATA-1:0] w_rshift;
    logic [NB_DATA-1:0] w_rdata;

    // latched access
    logic [NB_ADDR-1:0] r_addr;
    logic [1:0]         r_off;
    logic               r_we;
    logic [NB_MASK-1:0] r_mask;
    logic               r_uns;
    logic [NB_DATA-1:0] r_wdata;
    logic [3:0]         r_be;
    // completed-load results
    logic [NB_DATA-1:0] r_dato;
    logic [NB_MASK-1:0] r_omask;
    logic               r_ouns;
    logic               r_load_valid;
    logic               r_fault;

    // request decode, fault check, next state and stall
    always_comb begin
        w_req    = i_valid & (i_mem_read | i_mem_write);
        w_fault  = (i_mem_read & i_mem_write)
                 | (i_mascara == 2'b10)
                 | ((i_mascara == 2'b01) & i_addr[0])
                 | ((i_mascara == 2'b11) & (i_addr[1:0] != 2'b00));
        w_accept = (r_state == ST_IDLE) & w_req & ~w_fault;
        w_done   = (r_state == ST_ACCESS) & i_dmem_ack;
        w_next   = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_ACCESS;
            ST_ACCESS: if (i_dmem_ack) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        o_stall  = w_accept | ((r_state == ST_ACCESS) & ~i_dmem_ack);
    end

    // store lane replication and byte enables, little-endian lanes
    always_comb begin
        w_wdata_al = i_wdata;
        w_be       = 4'b1111;
        case (i_mascara)
            2'b00: begin
                w_wdata_al = {4{i_wdata[7:0]}};
                w_be       = 4'b0001 << i_addr[1:0];
            end
            2'b01: begin
                w_wdata_al = {2{i_wdata[15:0]}};
                w_be       = i_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata_al = i_wdata;
                w_be       = 4'b1111;
            end
        endcase
    end

    // right-justify the read word and zero everything above the access size
    always_comb begin
        w_rshift = i_dmem_rdata >> {r_off, 3'b000};
        case (r_mask)
            2'b00:   w_rdata = NB_DATA'(w_rshift[7:0]);
            2'b01:   w_rdata = NB_DATA'(w_rshift[15:0]);
            default: w_rdata = w_rshift;
        endcase
    end

    // state register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_next;
    end

    // capture the accepted request; held stable for the whole access
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_addr  <= '0;
            r_off   <= '0;
            r_we    <= 1'b0;
            r_mask  <= '0;
            r_uns   <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_addr  <= {i_addr[NB_ADDR-1:2], 2'b00};
            r_off   <= i_addr[1:0];
            r_we    <= i_mem_write;
            r_mask  <= i_mascara;
            r_uns   <= i_is_unsigned;
            r_wdata <= w_wdata_al;
            r_be    <= w_be;
        end
    end

    // load results held until the next load completes; fault/valid are pulses
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_dato       <= '0;
            r_omask      <= '0;
            r_ouns       <= 1'b0;
            r_load_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_load_valid <= w_done & ~r_we;
            r_fault      <= (r_state == ST_IDLE) & w_req & w_fault;
            if (w_done & ~r_we) begin
                r_dato  <= w_rdata;
                r_omask <= r_mask;
                r_ouns  <= r_uns;
            end
        end
    end

    assign o_dmem_req    = (r_state == ST_ACCESS);
    assign o_dmem_we     = r_we;
    assign o_dmem_addr   = r_addr;
    assign o_dmem_wdata  = r_wdata;
    assign o_dmem_be     = r_be;
    assign o_dato        = r_dato;
    assign o_mascara     = r_omask;
    assign o_is_unsigned = r_ouns;
    assign o_load_valid  = r_load_valid;
    assign o_fault       = r_fault;

endmodule
